// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver
//
// Turns the 24-bit RGB colour word into three PWM pins for a common-cathode
// RGB LED. Channel values are captured into shadow duty registers only at
// the start of a PWM period, so a colour change never glitches mid-period.
// A period is 256 ticks; one tick is PRESCALE clock cycles.
//
// Optional feature: define RGB_PWM_SOFT_FADE_EN to make the duties step by
// one toward the target at each period start instead of jumping to it.
//
// Parameters:
//   PRESCALE      clock cycles per PWM tick (>= 1)
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   enable        run/stop; low forces outputs low and clears the counters
//   light         target colour {R[23:16], G[15:8], B[7:0]}
//   pwm_r/g/b     registered PWM outputs
//   period_start  one-cycle pulse on the first cycle of each PWM period

module rgb_pwm_driver #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [23:0] light,
  output logic        pwm_r,
  output logic        pwm_g,
  output logic        pwm_b,
  output logic        period_start
);

  localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(PRESCALE - 1);

  logic [PreW-1:0]  pre_q, pre_d;
  logic [7:0]       cnt_q, cnt_d;
  // Index 2 = red, 1 = green, 0 = blue, matching the bit order of light.
  logic [2:0][7:0]  duty_q, duty_d;
  logic [2:0][7:0]  target;
  logic [2:0]       pwm_q, pwm_d;
  logic             period_start_q;
  logic             boundary;

`ifdef RGB_PWM_SOFT_FADE_EN
  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
    if (cur < tgt) begin
      return cur + 8'd1;
    end else if (cur > tgt) begin
      return cur - 8'd1;
    end
    return cur;
  endfunction
`endif

  assign target = light;

  always_comb begin
    boundary = enable && (cnt_q == 8'd0) && (pre_q == '0);

    pre_d = pre_q;
    cnt_d = cnt_q;
    if (!enable) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (pre_q == PreMax) begin
      pre_d = '0;
      cnt_d = cnt_q + 8'd1;
    end else begin
      pre_d = pre_q + 1'b1;
    end

    duty_d = duty_q;
    pwm_d  = '0;
    for (int i = 0; i < 3; i++) begin
      if (boundary) begin
`ifdef RGB_PWM_SOFT_FADE_EN
        duty_d[i] = step_toward(duty_q[i], target[i]);
`else
        duty_d[i] = target[i];
`endif
      end
      // duty_d is the effective duty: the freshly loaded value on a boundary
      // cycle, otherwise the held shadow value.
      pwm_d[i] = enable && (cnt_q < duty_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q          <= '0;
      cnt_q          <= '0;
      duty_q         <= '0;
      pwm_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      pre_q          <= pre_d;
      cnt_q          <= cnt_d;
      duty_q         <= duty_d;
      pwm_q          <= pwm_d;
      period_start_q <= boundary;
    end
  end

  assign pwm_r        = pwm_q[2];
  assign pwm_g        = pwm_q[1];
  assign pwm_b        = pwm_q[0];
  assign period_start = period_start_q;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed testbench for rgb_pwm_driver. Two instances share clock and
// reset: u_dut1 (PRESCALE=1) and u_dut4 (PRESCALE=4). Inputs change and
// outputs are sampled on the falling clock edge.

module tb_rgb_pwm_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        en1, en4;
  logic [23:0] light1, light4;
  logic        r1, g1, b1, ps1;
  logic        r4, g4, b4, ps4;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rgb_pwm_driver #(.PRESCALE(1)) u_dut1 (
    .clk          (clk),
    .rst          (rst),
    .enable       (en1),
    .light        (light1),
    .pwm_r        (r1),
    .pwm_g        (g1),
    .pwm_b        (b1),
    .period_start (ps1)
  );

  rgb_pwm_driver #(.PRESCALE(4)) u_dut4 (
    .clk          (clk),
    .rst          (rst),
    .enable       (en4),
    .light        (light4),
    .pwm_r        (r4),
    .pwm_g        (g4),
    .pwm_b        (b4),
    .period_start (ps4)
  );

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sample n consecutive cycles starting at the current falling edge; ends
  // on the falling edge after the last sample.
  task automatic measure(input bit use4, input int n,
                         output int hr, output int hg, output int hb, output int hp);
    hr = 0; hg = 0; hb = 0; hp = 0;
    repeat (n) begin
      if (use4) begin
        hr += int'(r4); hg += int'(g4); hb += int'(b4); hp += int'(ps4);
      end else begin
        hr += int'(r1); hg += int'(g1); hb += int'(b1); hp += int'(ps1);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int hr, hg, hb, hp;
    rst    = 1'b1;
    en1    = 1'b1;
    en4    = 1'b0;
    light1 = 24'hFFFFFF;
    light4 = 24'h000010;

    // Reset held for three cycles: every output stays low.
    repeat (3) begin
      @(negedge clk);
      check("rst_outs1", {r1, g1, b1, ps1}, 0);
      check("rst_outs4", {r4, g4, b4, ps4}, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ps", ps1, 1);
    check("post_rst_pwm", {r1, g1, b1}, 3'b111);

`ifdef RGB_PWM_SOFT_FADE_EN
    // Fade from black toward full blue: k ticks high in period k.
    light1 = 24'h0000FF;
    for (int k = 1; k <= 10; k++) begin
      measure(1'b0, 256, hr, hg, hb, hp);
      check($sformatf("fade_b_p%0d", k), hb, k);
      check($sformatf("fade_ps_p%0d", k), hp, 1);
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("fade_rst_outs", {r1, g1, b1, ps1}, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("fade_rerst_ps", ps1, 1);
    measure(1'b0, 256, hr, hg, hb, hp);
    check("fade_restart_p1", hb, 1);
    measure(1'b0, 256, hr, hg, hb, hp);
    check("fade_restart_p2", hb, 2);
`else
    // Light changed right after the boundary: ignored this period.
    light1 = 24'h8000FF;
    measure(1'b0, 256, hr, hg, hb, hp);
    check("p1_r", hr, 255);
    check("p1_g", hg, 255);
    check("p1_b", hb, 255);
    check("p1_ps", hp, 1);
    check("p2_start_ps", ps1, 1);
    measure(1'b0, 256, hr, hg, hb, hp);
    check("p2_r", hr, 128);
    check("p2_g", hg, 0);
    check("p2_b", hb, 255);
    check("p2_ps", hp, 1);

    // Red 0x40, then 0xC0 presented at cnt=100.
    light1 = 24'h400000;
    measure(1'b0, 256, hr, hg, hb, hp);
    check("p3_r", hr, 128);
    measure(1'b0, 100, hr, hg, hb, hp);
    light1 = 24'hC00000;
    begin
      int tr, tg, tb, tp;
      measure(1'b0, 156, tr, tg, tb, tp);
      check("mid_upd_cur_r", hr + tr, 64);
      check("mid_upd_cur_b", hb + tb, 0);
    end
    measure(1'b0, 256, hr, hg, hb, hp);
    check("mid_upd_next_r", hr, 192);
    check("mid_upd_next_ps", hp, 1);

    // Enable drop while the counter is at 50.
    measure(1'b0, 49, hr, hg, hb, hp);
    en1 = 1'b0;
    @(negedge clk);
    check("dis_pwm", {r1, g1, b1}, 0);
    check("dis_ps", ps1, 0);
    measure(1'b0, 5, hr, hg, hb, hp);
    check("dis_hold_r", hr, 0);
    check("dis_hold_ps", hp, 0);
    en1 = 1'b1;
    @(negedge clk);
    check("reen_ps", ps1, 1);
    check("reen_pwm", {r1, g1, b1}, 3'b100);
    measure(1'b0, 256, hr, hg, hb, hp);
    check("reen_r", hr, 192);
    check("reen_ps_count", hp, 1);
    check("reen_next_ps", ps1, 1);
`endif

    // PRESCALE=4, blue 0x10: 64 high cycles per 1024-cycle period.
    en4 = 1'b1;
    @(negedge clk);
    check("ps4_start", ps4, 1);
    measure(1'b1, 1024, hr, hg, hb, hp);
    check("ps4_b", hb, 64);
    check("ps4_r", hr, 0);
    check("ps4_ps", hp, 1);
    check("ps4_next_ps", ps4, 1);
    measure(1'b1, 1024, hr, hg, hb, hp);
    check("ps4_b2", hb, 64);
    check("ps4_ps2", hp, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
